window_reader: RTL and testbench

- Reads analysis windows of 2^WINDOW_SIZE_BITS samples out of the circular audio buffer (buffer_module) that the capture path fills.
- Acts as the read side of the buffer: it tracks the writer's pointer and starts a new window every HOP_SIZE new samples.
- Each window streams out oldest-first over a valid/ready interface toward the spectral/processing stage.
- Runs on the same clk as the writer.

---
 rtl/audio_buffer_pkg.sv | 17 +
 rtl/hop_scheduler.sv | 70 +++++++
 rtl/window_reader.sv | 129 ++++++++++++
 tb/tb_window_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_buffer_pkg.sv
// Shared audio buffer geometry and the window reader state encoding.
package audio_buffer_pkg;

  localparam int unsigned BufferSizeBits = 11;
  localparam int unsigned DataWidthBits  = 16;
  localparam int unsigned WindowSizeBits = 8;
  localparam int unsigned BufferDepth    = 1 << BufferSizeBits;
  localparam int unsigned WindowLen      = 1 << WindowSizeBits;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapture,
    StPresent
  } reader_state_e;

endpackage

// File: rtl/hop_scheduler.sv
// Decides when a window may start and flags writer overrun of unread window data.
module hop_scheduler
  import audio_buffer_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE_BITS = BufferSizeBits,
  parameter int unsigned WINDOW_SIZE_BITS = WindowSizeBits,
  parameter int unsigned HOP_SIZE         = 128
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sample_written,
  input  logic i_idle,
  input  logic i_start,
  output logic o_start_ok,
  output logic o_overrun
);

  localparam int unsigned Depth  = 1 << BUFFER_SIZE_BITS;
  localparam int unsigned WinLen = 1 << WINDOW_SIZE_BITS;
  localparam logic [WINDOW_SIZE_BITS:0]   FillFull = (WINDOW_SIZE_BITS + 1)'(WinLen);
  localparam logic [BUFFER_SIZE_BITS+1:0] NewMax   = (BUFFER_SIZE_BITS + 2)'(Depth);
  localparam logic [BUFFER_SIZE_BITS+1:0] Hop      = (BUFFER_SIZE_BITS + 2)'(HOP_SIZE);
  localparam logic [BUFFER_SIZE_BITS:0]   LagLimit = (BUFFER_SIZE_BITS + 1)'(Depth - WinLen);

  logic [WINDOW_SIZE_BITS:0]   r_fill;
  logic [BUFFER_SIZE_BITS:0]   r_new;
  logic [BUFFER_SIZE_BITS:0]   r_lag;
  logic                        r_overrun;
  logic [BUFFER_SIZE_BITS+1:0] w_new_sum;
  logic [BUFFER_SIZE_BITS:0]   w_new_next;
  logic                        w_new_sat;
  logic                        w_lag_over;

  // One extra bit of headroom so the +1 past saturation is visible before clipping.
  always_comb begin
    w_new_sum = {1'b0, r_new} + (BUFFER_SIZE_BITS + 2)'(i_sample_written);
    if (i_start) begin
      w_new_sum = w_new_sum - Hop;
    end
    w_new_sat  = (w_new_sum > NewMax);
    w_new_next = w_new_sat ? NewMax[BUFFER_SIZE_BITS:0] : w_new_sum[BUFFER_SIZE_BITS:0];
  end

  assign w_lag_over = !i_idle && (r_lag > LagLimit);
  assign o_start_ok = (r_fill == FillFull) && ({1'b0, r_new} >= Hop);
  assign o_overrun  = r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fill    <= '0;
      r_new     <= '0;
      r_lag     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_sample_written && (r_fill != FillFull)) begin
        r_fill <= r_fill + (WINDOW_SIZE_BITS + 1)'(1);
      end
      r_new <= w_new_next;
      if (i_start) begin
        r_lag <= (BUFFER_SIZE_BITS + 1)'(i_sample_written);
      end else if (i_sample_written && (r_lag != '1)) begin
        r_lag <= r_lag + (BUFFER_SIZE_BITS + 1)'(1);
      end
      if (w_lag_over || w_new_sat) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_reader.sv
// Streams 2^WINDOW_SIZE_BITS-sample windows oldest-first out of the circular audio buffer.
// Define WINDOW_READER_FRAME_TAG_EN to add the o_frame_idx window tag output.
module window_reader
  import audio_buffer_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE_BITS = BufferSizeBits,
  parameter int unsigned DATA_WIDTH_BITS  = DataWidthBits,
  parameter int unsigned WINDOW_SIZE_BITS = WindowSizeBits,
  parameter int unsigned HOP_SIZE         = 128
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [BUFFER_SIZE_BITS-1:0] i_wr_ptr,
  input  logic                        i_sample_written,
  output logic [BUFFER_SIZE_BITS-1:0] o_rd_address,
  output logic                        o_rd_oe,
  input  logic [DATA_WIDTH_BITS-1:0]  i_rd_data,
  output logic [DATA_WIDTH_BITS-1:0]  o_out_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic                        o_out_first,
  output logic                        o_out_last,
  output logic                        o_overrun
`ifdef WINDOW_READER_FRAME_TAG_EN
  ,
  output logic [15:0]                 o_frame_idx
`endif
);

  localparam int unsigned WinLen = 1 << WINDOW_SIZE_BITS;
  localparam logic [BUFFER_SIZE_BITS-1:0] WinAddr = BUFFER_SIZE_BITS'(WinLen);

  reader_state_e               r_state, w_state_next;
  logic [WINDOW_SIZE_BITS-1:0] r_idx;
  logic [BUFFER_SIZE_BITS-1:0] r_base;
  logic [DATA_WIDTH_BITS-1:0]  r_out_data;
  logic                        r_out_valid;
  logic                        r_first;
  logic                        r_last;
  logic                        w_start_ok;
  logic                        w_start;
  logic                        w_handshake;
  logic                        w_idx_last;

  hop_scheduler #(
    .BUFFER_SIZE_BITS(BUFFER_SIZE_BITS),
    .WINDOW_SIZE_BITS(WINDOW_SIZE_BITS),
    .HOP_SIZE        (HOP_SIZE)
  ) u_hop_scheduler (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_sample_written(i_sample_written),
    .i_idle          (r_state == StIdle),
    .i_start         (w_start),
    .o_start_ok      (w_start_ok),
    .o_overrun       (o_overrun)
  );

  assign w_start     = (r_state == StIdle) && w_start_ok;
  assign w_handshake = (r_state == StPresent) && r_out_valid && i_out_ready;
  assign w_idx_last  = &r_idx;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_start) w_state_next = StFetch;
      StFetch:   w_state_next = StCapture;
      StCapture: w_state_next = StPresent;
      StPresent: if (w_handshake) w_state_next = w_idx_last ? StIdle : StFetch;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_base      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_base <= i_wr_ptr - WinAddr;
        r_idx  <= '0;
      end
      // rd_data is only trusted here, one cycle after the FETCH address.
      if (r_state == StCapture) begin
        r_out_data  <= i_rd_data;
        r_out_valid <= 1'b1;
        r_first     <= (r_idx == '0);
        r_last      <= w_idx_last;
      end
      if (w_handshake) begin
        r_out_valid <= 1'b0;
        if (!w_idx_last) begin
          r_idx <= r_idx + WINDOW_SIZE_BITS'(1);
        end
      end
    end
  end

`ifdef WINDOW_READER_FRAME_TAG_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_frame_idx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
      r_frame_idx <= '0;
    end else if (w_start) begin
      r_frame_idx <= r_frame_cnt;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_idx = r_frame_idx;
`endif

  assign o_rd_address = r_base + BUFFER_SIZE_BITS'(r_idx);
  assign o_rd_oe      = (r_state == StFetch);
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_out_first  = r_first;
  assign o_out_last   = r_last;

endmodule

// File: tb/tb_window_reader.sv
// Directed bench for window_reader with a registered-read buffer and writer model.
module tb_window_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] wr_ptr;
  logic [10:0] wr_off;
  logic [10:0] wr_cnt;
  logic        sw;
  logic [10:0] rd_address;
  logic        rd_oe;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic        overrun;
`ifdef WINDOW_READER_FRAME_TAG_EN
  logic [15:0] frame_idx;
`endif

  logic [15:0] mem [0:2047];
  logic [15:0] seq = 16'h1000;
  int          n_checks = 0;
  int          n_errors = 0;
  int          win_cnt = 0;

  always #5 clk = ~clk;

  window_reader dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_wr_ptr        (wr_ptr),
    .i_sample_written(sw),
    .o_rd_address    (rd_address),
    .o_rd_oe         (rd_oe),
    .i_rd_data       (rd_data),
    .o_out_data      (out_data),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_first     (out_first),
    .o_out_last      (out_last),
    .o_overrun       (overrun)
`ifdef WINDOW_READER_FRAME_TAG_EN
    ,
    .o_frame_idx     (frame_idx)
`endif
  );

  // Writer commits at wr_ptr then advances; buffer read data lands one cycle after rd_oe.
  assign wr_ptr = wr_off + wr_cnt;
  always @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
    end else if (sw) begin
      mem[wr_ptr] <= seq;
      wr_cnt      <= wr_cnt + 11'd1;
      seq         <= seq + 16'd1;
    end
    rd_data <= rd_oe ? mem[rd_address] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_address", rd_address, 0);
    check("rst_rd_oe", rd_oe, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    check("rst_overrun", overrun, 0);
`ifdef WINDOW_READER_FRAME_TAG_EN
    check("rst_frame_idx", frame_idx, 0);
`endif
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("no_window", {rd_oe, out_valid}, 0);
      sw = 1'b1;
    end
    @(negedge clk);
    check("no_window", {rd_oe, out_valid}, 0);
    sw = 1'b0;
  endtask

  // Consumes one full window; n_wr writes run alongside, n_stall writes while the
  // first presented sample is held off.
  task automatic run_window(input logic [10:0] base, input bit rnd, input int n_wr,
                            input int n_stall, input int exp_gap, input int exp_cyc);
    int          idx, gap, cyc, wl, sl;
    bit          started, stalled, done;
    logic [15:0] exp_d, pd;
    logic        pf, pl;
    logic [10:0] ea;
    idx = 0; gap = 0; cyc = 0; wl = n_wr; sl = n_stall;
    started = 0; stalled = 0; done = 0; exp_d = '0; pd = '0; pf = 0; pl = 0;
    for (int t = 0; t < 8000 && !done; t++) begin
      @(negedge clk);
      if (!started && rd_oe) started = 1;
      if (!started) gap++;
      else cyc++;
      ea = base + 11'(idx);
      if (rd_oe) begin
        check("rd_address", rd_address, ea);
        exp_d = mem[ea];
      end
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_first", out_first, pf);
        check("stall_last", out_last, pl);
      end
      if (out_valid && sl > 0) begin
        out_ready = 1'b0;
        sw = 1'b1;
        sl--;
      end else begin
        out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        sw = (wl > 0);
        if (wl > 0) wl--;
      end
      stalled = out_valid && !out_ready;
      pd = out_data; pf = out_first; pl = out_last;
      if (out_valid && out_ready) begin
        check("data", out_data, exp_d);
        check("first", out_first, idx == 0);
        check("last", out_last, idx == 255);
`ifdef WINDOW_READER_FRAME_TAG_EN
        check("frame_idx", frame_idx, win_cnt);
`endif
        idx++;
        if (idx == 256) done = 1;
      end
    end
    sw = 1'b0;
    out_ready = 1'b1;
    check("handshakes", idx, 256);
    if (exp_gap >= 0) check("idle_gap", gap, exp_gap);
    if (exp_cyc >= 0) check("window_cycles", cyc, exp_cyc);
    win_cnt++;
  endtask

  initial begin
    reset = 1'b1; wr_off = '0; sw = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Fill to 255: nothing may start; the 256th sample starts base 0.
    pulses(255);
    repeat (5) begin
      @(negedge clk);
      check("no_window_255", {rd_oe, out_valid}, 0);
    end
    out_ready = 1'b1;
    pulses(1);
    run_window(11'd0, 1'b0, 128, 0, -1, 768);
    // new_cnt is 256 at this point: two hops pending, base advanced by 128.
    run_window(11'd128, 1'b1, 0, 0, 1, -1);
    run_window(11'd128, 1'b0, 0, 0, 1, 768);
    repeat (10) begin
      @(negedge clk);
      check("idle_after_hops", {rd_oe, out_valid}, 0);
    end
    check("no_overrun", overrun, 0);

    // Wrap-around: wr_ptr ends at 100, base 1892.
    @(negedge clk);
    reset = 1'b1; wr_off = 11'd1892;
    @(negedge clk);
    reset = 1'b0; win_cnt = 0;
    pulses(256);
    check("wr_ptr_wrapped", wr_ptr, 100);
    run_window(11'd1892, 1'b1, 0, 0, -1, -1);
    check("no_overrun_wrap", overrun, 0);

    // Stall the next window while the writer laps the unread data.
    run_window(11'd1892, 1'b0, 0, 1793, 1, -1);
    check("overrun_set", overrun, 1);
    repeat (3) @(negedge clk);
    check("overrun_sticky", overrun, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_quiet", {overrun, rd_oe, out_valid}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
